// File: rtl/apb_master_port.sv
// APB3 initiator: takes one command at a time, runs a SETUP/ACCESS transfer and returns data/status on a response handshake.
// Latency 3 cycles with zero wait states, +1 per PREADY-low cycle, bounded by TIMEOUT; the response holds until rsp_ready.
module apb_master_port #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 255
) (
   input  logic              PCLK,
   input  logic              PRESETn,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic              rsp_timeout,
   output logic              PSEL,
   output logic              PENABLE,
   output logic              PWRITE,
   output logic [ADDR_W-1:0] PADDR,
   output logic [DATA_W-1:0] PWDATA,
   input  logic [DATA_W-1:0] PRDATA,
   input  logic              PREADY,
   input  logic              PSLVERR
);

   // One-hot so every APB/handshake output is a decode of a single state flop.
   typedef enum logic [3:0] {
      ST_IDLE   = 4'b0001,
      ST_SETUP  = 4'b0010,
      ST_ACCESS = 4'b0100,
      ST_RESP   = 4'b1000
   } state_t;

   localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

   state_t     state_q;
   state_t     state_d;
   logic [7:0] wait_cnt;
   logic       cmd_fire;
   logic       wait_expired;

   assign cmd_fire     = cmd_valid && (state_q == ST_IDLE);
   // True on the edge that samples the TIMEOUT-th consecutive PREADY-low ACCESS cycle.
   assign wait_expired = (TIMEOUT_C != 8'd0) && !PREADY && ((wait_cnt + 8'd1) == TIMEOUT_C);

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:   if (cmd_fire) state_d = ST_SETUP;
         ST_SETUP:  state_d = ST_ACCESS;
         ST_ACCESS: if (PREADY || wait_expired) state_d = ST_RESP;
         ST_RESP:   if (rsp_ready) state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      cmd_ready = 1'b0;
      PSEL      = 1'b0;
      PENABLE   = 1'b0;
      rsp_valid = 1'b0;
      unique case (state_q)
         ST_IDLE:   cmd_ready = 1'b1;
         ST_SETUP:  PSEL      = 1'b1;
         ST_ACCESS: begin
            PSEL    = 1'b1;
            PENABLE = 1'b1;
         end
         ST_RESP:   rsp_valid = 1'b1;
         default:   cmd_ready = 1'b0;
      endcase
   end

   // Address/data hold their last values between transfers; response fields hold through RESP.
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         PADDR       <= '0;
         PWDATA      <= '0;
         PWRITE      <= 1'b0;
         rsp_rdata   <= '0;
         rsp_err     <= 1'b0;
         rsp_timeout <= 1'b0;
         wait_cnt    <= 8'd0;
      end else begin
         if (cmd_fire) begin
            PADDR    <= cmd_addr;
            PWRITE   <= cmd_write;
            PWDATA   <= cmd_write ? cmd_wdata : '0;
            wait_cnt <= 8'd0;
         end
         if (state_q == ST_ACCESS) begin
            if (PREADY) begin
               rsp_rdata   <= PWRITE ? '0 : PRDATA;
               rsp_err     <= PSLVERR;
               rsp_timeout <= 1'b0;
            end else begin
               wait_cnt <= wait_cnt + 8'd1;
               if (wait_expired) begin
                  rsp_rdata   <= '0;
                  rsp_err     <= 1'b1;
                  rsp_timeout <= 1'b1;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_apb_master_port.sv
// Bench for apb_master_port: randomized APB slave behaviour checked against a transaction-level model.
module tb_apb_master_port;
   localparam int TMO = 4;

   logic        PCLK, PRESETn;
   logic        cmd_valid, cmd_ready, cmd_write;
   logic [31:0] cmd_addr, cmd_wdata;
   logic        rsp_valid, rsp_ready, rsp_err, rsp_timeout;
   logic [31:0] rsp_rdata;
   logic        PSEL, PENABLE, PWRITE, PREADY, PSLVERR;
   logic [31:0] PADDR, PWDATA, PRDATA;

   int total = 0;
   int bad   = 0;

   apb_master_port #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TMO)) dut (
      .PCLK(PCLK), .PRESETn(PRESETn),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
      .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
      .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
   );

   initial PCLK = 1'b0;
   always #5 PCLK = ~PCLK;

   typedef struct {
      int          lat;
      int          pen;
      int          setup;
      bit          moved;
      logic [31:0] paddr;
      logic [31:0] pwdata;
      logic        pwrite;
      logic [31:0] rdata;
      logic        err;
      logic        tmo;
      int          hold_bad;
      logic        after_vld;
      logic        after_rdy;
      logic        after_psel;
   } obs_t;

   typedef struct {
      int          lat;
      int          pen;
      logic [31:0] rdata;
      logic        err;
      logic        tmo;
   } exp_t;

   // Transaction-level expectation: slave stalls `waits` ACCESS cycles, then completes unless TMO lows come first.
   function automatic exp_t model(bit wr, int waits, bit slverr, logic [31:0] prdata);
      exp_t e;
      bit   tmo;
      tmo     = (TMO != 0) && (waits >= TMO);
      e.tmo   = tmo;
      e.err   = tmo | slverr;
      e.rdata = (tmo || wr) ? 32'd0 : prdata;
      e.pen   = tmo ? TMO : waits + 1;
      e.lat   = e.pen + 2;
      return e;
   endfunction

   // Drives one command from a negedge, plays the slave, holds the response `hold` cycles, then consumes it.
   task automatic do_xfer(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input int waits, input bit slverr, input logic [31:0] prdata,
                          input int hold, input bit nxt_v, input bit nxt_wr,
                          input logic [31:0] nxt_addr, input logic [31:0] nxt_wdata,
                          output obs_t o);
      int n;
      int pen;
      o = '{default: 0};
      cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata; rsp_ready = 1'b0;
      PREADY = 1'($urandom); PSLVERR = 1'($urandom); PRDATA = $urandom;
      n = 0; pen = 0;
      while (rsp_valid !== 1'b1 && n < 60) begin
         @(posedge PCLK);
         n++;
         @(negedge PCLK);
         cmd_valid = 1'b0;
         if (PSEL === 1'b1 && PENABLE === 1'b0) o.setup++;
         if (PSEL === 1'b1) begin
            if (o.setup == 1 && pen == 0) begin
               o.paddr = PADDR; o.pwdata = PWDATA; o.pwrite = PWRITE;
            end else if (PADDR !== o.paddr || PWDATA !== o.pwdata || PWRITE !== o.pwrite) begin
               o.moved = 1'b1;
            end
         end
         if (PENABLE === 1'b1) begin
            pen++;
            PREADY  = (pen > waits);
            PSLVERR = PREADY ? slverr : 1'($urandom);
            PRDATA  = PREADY ? prdata : $urandom;
         end else begin
            PREADY = 1'($urandom); PSLVERR = 1'($urandom); PRDATA = $urandom;
         end
      end
      o.lat = n; o.pen = pen;
      o.rdata = rsp_rdata; o.err = rsp_err; o.tmo = rsp_timeout;
      if (nxt_v) begin
         cmd_valid = 1'b1; cmd_write = nxt_wr; cmd_addr = nxt_addr; cmd_wdata = nxt_wdata;
      end
      for (int h = 0; h < hold; h++) begin
         @(posedge PCLK);
         @(negedge PCLK);
         if (rsp_valid !== 1'b1 || rsp_rdata !== o.rdata || rsp_err !== o.err ||
             rsp_timeout !== o.tmo || cmd_ready !== 1'b0 || PSEL !== 1'b0)
            o.hold_bad++;
      end
      rsp_ready = 1'b1;
      @(posedge PCLK);
      @(negedge PCLK);
      rsp_ready = 1'b0;
      o.after_vld = rsp_valid; o.after_rdy = cmd_ready; o.after_psel = PSEL;
   endtask

   task automatic test_reset();
      PRESETn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
      rsp_ready = 1'b0; PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = '0;
      @(negedge PCLK);
      total++;
      if ({PSEL, PENABLE, PWRITE, rsp_valid, rsp_err, rsp_timeout} !== 6'b0 ||
          PADDR !== 32'd0 || PWDATA !== 32'd0 || rsp_rdata !== 32'd0) begin
         bad++;
         $display("FAIL reset_outputs: got ctl=%b paddr=%h pwdata=%h rdata=%h want all 0",
                  {PSEL, PENABLE, PWRITE, rsp_valid, rsp_err, rsp_timeout}, PADDR, PWDATA, rsp_rdata);
      end
      total++;
      if (cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready); end
      @(negedge PCLK);
      PRESETn = 1'b1;
   endtask

   task automatic test_write();
      obs_t o; exp_t e;
      do_xfer(1'b1, 32'h4, 32'hA5, 0, 1'b0, 32'hDEAD_BEEF, 0, 1'b0, 1'b0, '0, '0, o);
      e = model(1'b1, 0, 1'b0, 32'hDEAD_BEEF);
      total++; if (o.lat !== e.lat)   begin bad++; $display("FAIL wr_latency: got %0d want %0d", o.lat, e.lat); end
      total++; if (o.setup !== 1)     begin bad++; $display("FAIL wr_setup_cycles: got %0d want 1", o.setup); end
      total++; if (o.pen !== e.pen)   begin bad++; $display("FAIL wr_penable_cycles: got %0d want %0d", o.pen, e.pen); end
      total++; if (o.pwdata !== 32'hA5 || o.paddr !== 32'h4 || o.pwrite !== 1'b1 || o.moved)
         begin bad++; $display("FAIL wr_apb_fields: got a=%h d=%h w=%b moved=%b want a=4 d=a5 w=1 moved=0", o.paddr, o.pwdata, o.pwrite, o.moved); end
      total++; if (o.err !== e.err || o.rdata !== e.rdata || o.tmo !== e.tmo)
         begin bad++; $display("FAIL wr_rsp: got err=%b rdata=%h to=%b want err=%b rdata=%h to=%b", o.err, o.rdata, o.tmo, e.err, e.rdata, e.tmo); end
      total++; if (o.after_vld !== 1'b0 || o.after_rdy !== 1'b1)
         begin bad++; $display("FAIL wr_release: got vld=%b rdy=%b want 0 1", o.after_vld, o.after_rdy); end
   endtask

   task automatic test_read();
      obs_t o; exp_t e;
      do_xfer(1'b0, 32'hC, 32'hFFFF_FFFF, 0, 1'b0, 32'h1, 0, 1'b0, 1'b0, '0, '0, o);
      e = model(1'b0, 0, 1'b0, 32'h1);
      total++; if (o.rdata !== 32'h1 || o.err !== 1'b0)
         begin bad++; $display("FAIL rd_rsp: got rdata=%h err=%b want 1 0", o.rdata, o.err); end
      total++; if (o.pwdata !== 32'h0 || o.moved || o.paddr !== 32'hC)
         begin bad++; $display("FAIL rd_pwdata: got d=%h a=%h moved=%b want 0 c 0", o.pwdata, o.paddr, o.moved); end
      total++; if (o.lat !== e.lat) begin bad++; $display("FAIL rd_latency: got %0d want %0d", o.lat, e.lat); end
   endtask

   task automatic test_wait_states();
      obs_t o;
      // Completion lands on the edge where the counter would reach TMO, so it must not time out.
      do_xfer(1'b0, 32'h4, 32'h0, 3, 1'b0, 32'h5A, 0, 1'b0, 1'b0, '0, '0, o);
      total++; if (o.pen !== 4) begin bad++; $display("FAIL ws_penable_cycles: got %0d want 4", o.pen); end
      total++; if (o.lat !== 6) begin bad++; $display("FAIL ws_latency: got %0d want 6", o.lat); end
      total++; if (o.paddr !== 32'h4 || o.moved)
         begin bad++; $display("FAIL ws_paddr: got %h moved=%b want 4 0", o.paddr, o.moved); end
      total++; if (o.rdata !== 32'h5A || o.tmo !== 1'b0 || o.err !== 1'b0)
         begin bad++; $display("FAIL ws_rsp: got rdata=%h to=%b err=%b want 5a 0 0", o.rdata, o.tmo, o.err); end
   endtask

   task automatic test_error_timeout();
      obs_t o;
      do_xfer(1'b1, 32'h8, 32'h33, 0, 1'b1, 32'h0, 0, 1'b0, 1'b0, '0, '0, o);
      total++; if (o.err !== 1'b1 || o.tmo !== 1'b0)
         begin bad++; $display("FAIL slverr_rsp: got err=%b to=%b want 1 0", o.err, o.tmo); end
      do_xfer(1'b0, 32'h10, 32'h0, 1000, 1'b0, 32'h77, 0, 1'b0, 1'b0, '0, '0, o);
      total++; if (o.pen !== TMO) begin bad++; $display("FAIL tmo_penable_cycles: got %0d want %0d", o.pen, TMO); end
      total++; if (o.err !== 1'b1 || o.tmo !== 1'b1 || o.rdata !== 32'h0)
         begin bad++; $display("FAIL tmo_rsp: got err=%b to=%b rdata=%h want 1 1 0", o.err, o.tmo, o.rdata); end
      total++; if (o.lat !== TMO + 2) begin bad++; $display("FAIL tmo_latency: got %0d want %0d", o.lat, TMO + 2); end
   endtask

   task automatic test_backpressure();
      obs_t o;
      do_xfer(1'b0, 32'h20, 32'h0, 1, 1'b0, 32'hCAFE_0001, 5, 1'b1, 1'b1, 32'h24, 32'h1234_5678, o);
      total++; if (o.hold_bad !== 0) begin bad++; $display("FAIL bp_hold: got %0d bad cycles want 0", o.hold_bad); end
      total++; if (o.rdata !== 32'hCAFE_0001) begin bad++; $display("FAIL bp_rdata: got %h want cafe0001", o.rdata); end
      total++; if (o.after_rdy !== 1'b1 || o.after_psel !== 1'b0 || o.after_vld !== 1'b0)
         begin bad++; $display("FAIL bp_release: got rdy=%b psel=%b vld=%b want 1 0 0", o.after_rdy, o.after_psel, o.after_vld); end
      do_xfer(1'b1, 32'h24, 32'h1234_5678, 0, 1'b0, 32'h0, 0, 1'b0, 1'b0, '0, '0, o);
      total++; if (o.lat !== 3 || o.paddr !== 32'h24 || o.pwdata !== 32'h1234_5678)
         begin bad++; $display("FAIL bp_second_cmd: got lat=%0d a=%h d=%h want 3 24 12345678", o.lat, o.paddr, o.pwdata); end
   endtask

   task automatic test_reset_mid_access();
      int  n, pen;
      bit  seen;
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h8; cmd_wdata = '0; rsp_ready = 1'b1;
      PREADY = 1'b0; n = 0; pen = 0;
      while (pen < 2 && n < 20) begin
         @(posedge PCLK);
         n++;
         @(negedge PCLK);
         cmd_valid = 1'b0;
         PREADY = 1'b0;
         if (PENABLE === 1'b1) pen++;
      end
      total++; if (pen !== 2) begin bad++; $display("FAIL rst_reach_wait: got %0d access cycles want 2", pen); end
      PRESETn = 1'b0;
      #1;
      total++; if ({PSEL, PENABLE, rsp_valid} !== 3'b000)
         begin bad++; $display("FAIL rst_immediate: got psel/pen/vld=%b want 000", {PSEL, PENABLE, rsp_valid}); end
      @(negedge PCLK);
      PRESETn = 1'b1; PREADY = 1'b1;
      seen = 1'b0;
      repeat (6) begin
         @(posedge PCLK);
         @(negedge PCLK);
         if (rsp_valid !== 1'b0 || PSEL !== 1'b0) seen = 1'b1;
      end
      total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL rst_cmd_ready: got %b want 1", cmd_ready); end
      total++; if (seen) begin bad++; $display("FAIL rst_no_response: got activity after reset want none"); end
      rsp_ready = 1'b0;
   endtask

   task automatic test_random();
      obs_t        o;
      exp_t        e;
      bit          wr, se;
      int          waits, hold;
      logic [31:0] a, d, rd;
      for (int i = 0; i < 40; i++) begin
         wr = 1'($urandom); se = 1'($urandom); a = $urandom; d = $urandom; rd = $urandom;
         waits = $urandom_range(0, 6); hold = $urandom_range(0, 3);
         do_xfer(wr, a, d, waits, se, rd, hold, 1'b0, 1'b0, '0, '0, o);
         e = model(wr, waits, se, rd);
         total++;
         if (o.lat !== e.lat || o.pen !== e.pen || o.setup !== 1)
            begin bad++; $display("FAIL rnd%0d_timing: got lat=%0d pen=%0d setup=%0d want %0d %0d 1", i, o.lat, o.pen, o.setup, e.lat, e.pen); end
         total++;
         if (o.rdata !== e.rdata || o.err !== e.err || o.tmo !== e.tmo)
            begin bad++; $display("FAIL rnd%0d_rsp: got rdata=%h err=%b to=%b want %h %b %b", i, o.rdata, o.err, o.tmo, e.rdata, e.err, e.tmo); end
         total++;
         if (o.paddr !== a || o.pwrite !== wr || o.pwdata !== (wr ? d : 32'd0) || o.moved)
            begin bad++; $display("FAIL rnd%0d_apb: got a=%h w=%b d=%h moved=%b want %h %b %h 0", i, o.paddr, o.pwrite, o.pwdata, o.moved, a, wr, wr ? d : 32'd0); end
         total++;
         if (o.hold_bad !== 0 || o.after_vld !== 1'b0 || o.after_rdy !== 1'b1)
            begin bad++; $display("FAIL rnd%0d_handshake: got hold_bad=%0d vld=%b rdy=%b want 0 0 1", i, o.hold_bad, o.after_vld, o.after_rdy); end
      end
   endtask

   initial begin
      test_reset();
      test_write();
      test_read();
      test_wait_states();
      test_error_timeout();
      test_backpressure();
      test_reset_mid_access();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation still running at time %0t, want finished", $time);
      $fatal(1);
   end
endmodule
